// File: rtl/gateway_recv_arb_if.sv
// -----------------------------------------------------------------------------
// gateway_recv_arb_if
// AXI4-Stream (routed) bundle used on both sides of the receive-side arbiter.
//   tvalid/tready : per-beat handshake
//   tdata/tkeep   : payload and byte enables
//   tlast         : final beat of a packet
//   tdest         : 14-bit routing word; tdest[9:6] carries the sender id
// Modports:
//   master : drives the beat, samples tready
//   slave  : samples the beat, drives tready
// -----------------------------------------------------------------------------
interface gateway_recv_arb_if #(
    parameter int DATA_W = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [13:0]           tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tdest,
        output tready
    );
endinterface

// File: rtl/gateway_recv_arb.sv
// -----------------------------------------------------------------------------
// gateway_recv_arb
// Packet-level round-robin arbiter merging N_SRC receive streams into the
// single stream feeding gateway_recv. The sender id of each packet's first
// beat is checked against the trusted region ids and the host-programmed
// route_ctrl; rejected packets are drained and counted, never forwarded.
//
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   route_ctrl    : capability word, [9:6] = allowed P2P sender (0 = any)
//   s_axis_src[]  : input streams (slave side)
//   m_axis        : merged output stream (master side)
//   cur_src       : index of the granted source
//   busy          : a packet is granted (forwarding or draining)
//   drop_pulse    : one-cycle pulse after the final beat of a dropped packet
//   drop_cnt      : saturating count of dropped packets
// -----------------------------------------------------------------------------
module gateway_recv_arb #(
    parameter int  N_SRC      = 4,
    parameter int  N_REGIONS  = 2,
    parameter int  ID         = 0,
    parameter int  DROP_CNT_W = 16,
    parameter int  DATA_W     = 32,
    localparam int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [13:0]           route_ctrl,
    gateway_recv_arb_if.slave     s_axis_src [N_SRC],
    gateway_recv_arb_if.master    m_axis,
    output logic [SRC_W-1:0]      cur_src,
    output logic                  busy,
    output logic                  drop_pulse,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Region-owned sender ids that are always accepted.
    localparam logic [3:0]       TRUST_0  = 4'(N_REGIONS);
    localparam logic [3:0]       TRUST_1  = 4'(N_REGIONS + 2);
    localparam logic [3:0]       TRUST_2  = 4'(N_REGIONS + 3);
    localparam logic [3:0]       TRUST_3  = 4'(N_REGIONS + 4);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_SRC - 1);

    // Source index following idx, wrapping at N_SRC (not at 2**SRC_W).
    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx);
        return (idx == LAST_IDX) ? {SRC_W{1'b0}} : (idx + SRC_W'(1));
    endfunction

    // A packet is accepted when its sender is trusted, matches the allowed
    // P2P sender, or the host left the allowed sender at 0 (any sender).
    function automatic logic sender_ok(input logic [3:0] sender,
                                       input logic [3:0] allowed);
        return (sender == TRUST_0) || (sender == TRUST_1) ||
               (sender == TRUST_2) || (sender == TRUST_3) ||
               (allowed == 4'd0)   || (sender == allowed);
    endfunction

    state_t                  state_q, state_d;
    logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]        cur_src_q, cur_src_d;
    logic                    busy_q, busy_d;
    logic                    drop_pulse_q, drop_pulse_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [N_SRC-1:0]        src_tvalid_s;
    logic [N_SRC-1:0]        src_tlast_s;
    logic [N_SRC-1:0]        src_tready_s;
    logic [DATA_W-1:0]       src_tdata_s [N_SRC];
    logic [DATA_W/8-1:0]     src_tkeep_s [N_SRC];
    logic [13:0]             src_tdest_s [N_SRC];

    logic                    found_s;
    logic [SRC_W-1:0]        win_idx_s;
    logic                    m_tvalid_s;
    logic                    unused_s;

    // Only the allowed-sender field of route_ctrl matters here; ID is informational.
    assign unused_s = ^{route_ctrl[13:10], route_ctrl[5:0], 32'(ID)};

    // Interface arrays need constant indices, so flatten them into plain arrays
    // that can be muxed by cur_src_q.
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_tvalid_s[g]     = s_axis_src[g].tvalid;
        assign src_tlast_s[g]      = s_axis_src[g].tlast;
        assign src_tdata_s[g]      = s_axis_src[g].tdata;
        assign src_tkeep_s[g]      = s_axis_src[g].tkeep;
        assign src_tdest_s[g]      = s_axis_src[g].tdest;
        assign s_axis_src[g].tready = src_tready_s[g];
    end

    // Round-robin search: first valid source starting at rr_ptr_q.
    always_comb begin
        int               cand_raw;
        logic [SRC_W-1:0] cand;
        found_s   = 1'b0;
        win_idx_s = rr_ptr_q;
        cand_raw  = 0;
        cand      = {SRC_W{1'b0}};
        for (int k = 0; k < N_SRC; k++) begin
            cand_raw  = int'(rr_ptr_q) + k;
            cand      = (cand_raw >= N_SRC) ? SRC_W'(cand_raw - N_SRC) : SRC_W'(cand_raw);
            win_idx_s = (!found_s && src_tvalid_s[cand]) ? cand : win_idx_s;
            found_s   = found_s | src_tvalid_s[cand];
        end
    end

    // Output mux: zero-latency pass-through of the granted source while
    // forwarding; tvalid is independent of m_axis.tready.
    always_comb begin
        m_tvalid_s   = (state_q == ST_FWD) && src_tvalid_s[cur_src_q];
        src_tready_s = {N_SRC{1'b0}};
        case (state_q)
            ST_FWD:  src_tready_s[cur_src_q] = m_axis.tready;
            ST_DROP: src_tready_s[cur_src_q] = 1'b1;
            default: src_tready_s = {N_SRC{1'b0}};
        endcase
    end

    assign m_axis.tvalid = m_tvalid_s;
    assign m_axis.tdata  = src_tdata_s[cur_src_q];
    assign m_axis.tkeep  = src_tkeep_s[cur_src_q];
    assign m_axis.tlast  = src_tlast_s[cur_src_q];
    assign m_axis.tdest  = src_tdest_s[cur_src_q];

    // Next-state logic. route_ctrl is consulted only in the IDLE decision
    // cycle, so the verdict on a packet never changes after its first beat.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_src_d    = cur_src_q;
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    cur_src_d = win_idx_s;
                    state_d   = sender_ok(src_tdest_s[win_idx_s][9:6], route_ctrl[9:6])
                                ? ST_FWD : ST_DROP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (m_tvalid_s && m_axis.tready && src_tlast_s[cur_src_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_src(cur_src_q);
                end else begin
                    state_d = ST_FWD;
                end
            end
            ST_DROP: begin
                if (src_tvalid_s[cur_src_q] && src_tlast_s[cur_src_q]) begin
                    state_d      = ST_IDLE;
                    rr_ptr_d     = next_src(cur_src_q);
                    drop_pulse_d = 1'b1;
                    drop_cnt_d   = (drop_cnt_q == {DROP_CNT_W{1'b1}})
                                   ? drop_cnt_q : (drop_cnt_q + DROP_CNT_W'(1));
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered status outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= {SRC_W{1'b0}};
            cur_src_q    <= {SRC_W{1'b0}};
            busy_q       <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= {DROP_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_src_q    <= cur_src_d;
            busy_q       <= busy_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign cur_src    = cur_src_q;
    assign busy       = busy_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_gateway_recv_arb.sv
// -----------------------------------------------------------------------------
// tb_gateway_recv_arb
// Directed self-checking bench for gateway_recv_arb (4 sources, 2 regions,
// 2-bit drop counter). Sources are fed from per-source beat tables; every
// beat accepted on m_axis and every drop pulse is logged and compared with
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_gateway_recv_arb;
    localparam int NS = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [13:0] route_ctrl = 14'h0;

    logic        src_tvalid [NS];
    logic        src_tready [NS];
    logic [31:0] src_tdata  [NS];
    logic [3:0]  src_tkeep  [NS];
    logic        src_tlast  [NS];
    logic [13:0] src_tdest  [NS];

    logic        m_tready = 1'b1;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [13:0] m_tdest;

    logic [1:0]  cur_src;
    logic        busy;
    logic        drop_pulse;
    logic [1:0]  drop_cnt;

    // Per-source beat tables
    logic [31:0] q_data [NS][64];
    logic [13:0] q_dest [NS][64];
    logic        q_last [NS][64];
    logic [3:0]  q_keep [NS][64];
    int          wr [NS];
    int          rd [NS];
    logic        gap [NS];
    logic        gap_en [NS];
    logic        rand_rdy = 1'b0;

    // Observation log
    logic [31:0] obs_data [256];
    logic [13:0] obs_dest [256];
    logic        obs_last [256];
    logic [3:0]  obs_keep [256];
    logic [1:0]  obs_src  [256];
    int          obs_cyc  [256];
    int          n_obs;
    logic [1:0]  pulse_log [16];
    int          n_pulse;
    int          cyc = 0;
    int          first_v;
    int          viol;
    int          stall_cnt [NS];

    int          errors = 0;
    int          checks = 0;

    gateway_recv_arb_if #(.DATA_W(32)) src_if [NS] ();
    gateway_recv_arb_if #(.DATA_W(32)) m_if ();

    for (genvar g = 0; g < NS; g++) begin : g_src
        assign src_if[g].tvalid = src_tvalid[g];
        assign src_if[g].tdata  = src_tdata[g];
        assign src_if[g].tkeep  = src_tkeep[g];
        assign src_if[g].tlast  = src_tlast[g];
        assign src_if[g].tdest  = src_tdest[g];
        assign src_tready[g]    = src_if[g].tready;
    end

    assign m_if.tready = m_tready;
    assign m_tvalid    = m_if.tvalid;
    assign m_tdata     = m_if.tdata;
    assign m_tkeep     = m_if.tkeep;
    assign m_tlast     = m_if.tlast;
    assign m_tdest     = m_if.tdest;

    gateway_recv_arb #(
        .N_SRC(4), .N_REGIONS(2), .ID(0), .DROP_CNT_W(2), .DATA_W(32)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .route_ctrl(route_ctrl),
        .s_axis_src(src_if), .m_axis(m_if),
        .cur_src(cur_src), .busy(busy), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] mk_data(input int s, input int p, input int b);
        return {8'hA5, 8'(s), 8'(p), 8'(b)};
    endfunction

    // Later beats carry sender 0xF so any per-beat re-check would be visible.
    function automatic logic [13:0] mk_dest(input logic [3:0] snd, input int b);
        return {4'h0, (b == 0) ? snd : 4'hF, 6'(b)};
    endfunction

    task automatic add_pkt(input int s, input int p, input int len, input logic [3:0] snd);
        for (int b = 0; b < len; b++) begin
            q_data[s][wr[s]] = mk_data(s, p, b);
            q_dest[s][wr[s]] = mk_dest(snd, b);
            q_last[s][wr[s]] = (b == len - 1);
            q_keep[s][wr[s]] = (b == len - 1) ? 4'h3 : 4'hF;
            wr[s]++;
        end
    endtask

    task automatic clear_logs();
        n_obs = 0;
        n_pulse = 0;
        first_v = -1;
        viol = 0;
        for (int i = 0; i < NS; i++) stall_cnt[i] = 0;
    endtask

    // One clock: observe at negedge, then advance sources after posedge.
    task automatic cycle();
        logic hs [NS];
        @(negedge aclk);
        cyc++;
        if (first_v < 0 && (src_tvalid[0] || src_tvalid[1] || src_tvalid[2] || src_tvalid[3]))
            first_v = cyc;
        for (int i = 0; i < NS; i++) begin
            hs[i] = src_tvalid[i] && src_tready[i];
            if (src_tvalid[i] && !src_tready[i]) stall_cnt[i]++;
            if (src_tready[i] && (!busy || cur_src != 2'(i))) viol++;
        end
        if (m_tvalid && m_tready && n_obs < 256) begin
            obs_data[n_obs] = m_tdata;
            obs_dest[n_obs] = m_tdest;
            obs_last[n_obs] = m_tlast;
            obs_keep[n_obs] = m_tkeep;
            obs_src[n_obs]  = cur_src;
            obs_cyc[n_obs]  = cyc;
            n_obs++;
        end
        if (drop_pulse && n_pulse < 16) begin
            pulse_log[n_pulse] = drop_cnt;
            n_pulse++;
        end
        @(posedge aclk);
        #1;
        m_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                rd[i]++;
                gap[i] = gap_en[i] && ($urandom_range(0, 2) == 0);
            end else begin
                gap[i] = 1'b0;
            end
            if (rd[i] < wr[i] && !gap[i]) begin
                src_tvalid[i] = 1'b1;
                src_tdata[i]  = q_data[i][rd[i]];
                src_tdest[i]  = q_dest[i][rd[i]];
                src_tlast[i]  = q_last[i][rd[i]];
                src_tkeep[i]  = q_keep[i][rd[i]];
            end else begin
                src_tvalid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int  n = 0;
        logic pend;
        do begin
            cycle();
            n++;
            pend = busy;
            for (int i = 0; i < NS; i++) if (rd[i] < wr[i]) pend = 1'b1;
        end while (pend && n < bound);
        cycle();
        cycle();
        checks++;
        if (pend) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", tag, bound);
        end
    endtask

    task automatic run_until_obs(input int want, input int bound, input string tag);
        int n = 0;
        while (n_obs < want && n < bound) begin
            cycle();
            n++;
        end
        checks++;
        if (n_obs < want) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats, want %0d", tag, n_obs, want);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m_tready = 1'b1;
        rand_rdy = 1'b0;
        for (int i = 0; i < NS; i++) begin
            wr[i] = 0; rd[i] = 0; gap[i] = 1'b0; gap_en[i] = 1'b0;
            src_tvalid[i] = 1'b0; src_tdata[i] = 32'h0; src_tkeep[i] = 4'h0;
            src_tlast[i] = 1'b0; src_tdest[i] = 14'h0;
        end
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        logic any_rdy;
        aresetn = 1'b0;
        #12;
        any_rdy = src_tready[0] | src_tready[1] | src_tready[2] | src_tready[3];
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        checks++; if (any_rdy !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", any_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b want 0", drop_pulse); end
        checks++; if (drop_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", drop_cnt); end
        checks++; if (cur_src !== 2'd0) begin errors++; $display("FAIL rst_cur_src: got %0d want 0", cur_src); end
        do_reset();
        clear_logs();
        repeat (3) cycle();
        checks++; if (busy !== 1'b0 || n_obs !== 0) begin errors++; $display("FAIL idle_quiet: busy=%b beats=%0d want 0/0", busy, n_obs); end
    endtask

    task automatic test_host_alone();
        clear_logs();
        route_ctrl = 14'h0C0;
        add_pkt(0, 0, 3, 4'd2);
        wait_idle(50, "host");
        checks++; if (n_obs !== 3) begin errors++; $display("FAIL host_nbeats: got %0d want 3", n_obs); end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (obs_data[b] !== mk_data(0, 0, b) || obs_dest[b] !== mk_dest(4'd2, b) ||
                obs_last[b] !== (b == 2) || obs_keep[b] !== ((b == 2) ? 4'h3 : 4'hF)) begin
                errors++;
                $display("FAIL host_beat%0d: got %h/%h/%b/%h want %h/%h", b, obs_data[b],
                         obs_dest[b], obs_last[b], obs_keep[b], mk_data(0, 0, b), mk_dest(4'd2, b));
            end
            checks++;
            if (obs_cyc[b] !== first_v + 1 + b) begin
                errors++; $display("FAIL host_latency%0d: got cycle %0d want %0d", b, obs_cyc[b], first_v + 1 + b);
            end
        end
        checks++; if (drop_cnt !== 2'd0) begin errors++; $display("FAIL host_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_p2p();
        route_ctrl = 14'h040;
        clear_logs();
        add_pkt(1, 0, 2, 4'd1);
        wait_idle(50, "p2p_ok");
        checks++; if (n_obs !== 2 || obs_src[0] !== 2'd1 || obs_data[1] !== mk_data(1, 0, 1)) begin
            errors++; $display("FAIL p2p_allowed: beats=%0d src=%0d data=%h want 2/1/%h", n_obs, obs_src[0], obs_data[1], mk_data(1, 0, 1));
        end
        clear_logs();
        add_pkt(1, 1, 4, 4'd0);
        wait_idle(50, "p2p_rej");
        checks++; if (n_obs !== 0) begin errors++; $display("FAIL p2p_rej_fwd: got %0d beats want 0", n_obs); end
        checks++; if (n_pulse !== 1) begin errors++; $display("FAIL p2p_rej_pulse: got %0d want 1", n_pulse); end
        checks++; if (drop_cnt !== 2'd1) begin errors++; $display("FAIL p2p_rej_cnt: got %0d want 1", drop_cnt); end
        checks++; if (stall_cnt[1] !== 1) begin errors++; $display("FAIL p2p_rej_drain: stalls=%0d want 1", stall_cnt[1]); end
        route_ctrl = 14'h000;
        clear_logs();
        add_pkt(1, 2, 2, 4'd0);
        wait_idle(50, "p2p_any");
        checks++; if (n_obs !== 2 || n_pulse !== 0) begin
            errors++; $display("FAIL p2p_any: beats=%0d pulses=%0d want 2/0", n_obs, n_pulse);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        route_ctrl = 14'h000;
        clear_logs();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) add_pkt(s, p, 2, 4'd2);
        wait_idle(100, "rr");
        checks++; if (n_obs !== 16) begin errors++; $display("FAIL rr_nbeats: got %0d want 16", n_obs); end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (obs_src[j] !== 2'((j / 2) % 4) || obs_data[j] !== mk_data((j / 2) % 4, j / 8, j % 2) ||
                obs_cyc[j] !== obs_cyc[0] + 3 * (j / 2) + (j % 2)) begin
                errors++;
                $display("FAIL rr_beat%0d: src=%0d data=%h cyc=%0d want %0d/%h/%0d", j, obs_src[j], obs_data[j],
                         obs_cyc[j], (j / 2) % 4, mk_data((j / 2) % 4, j / 8, j % 2), obs_cyc[0] + 3 * (j / 2) + (j % 2));
            end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rr_tready: violations=%0d want 0", viol); end
    endtask

    task automatic test_backpressure();
        int nb [NS];
        logic [3:0] snd;
        route_ctrl = 14'h0C0;
        clear_logs();
        rand_rdy = 1'b1;
        gap_en[2] = 1'b1;
        gap_en[3] = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < NS; s++) add_pkt(s, p, 4, 4'(s + 2));
        wait_idle(3000, "bp");
        rand_rdy = 1'b0;
        gap_en[2] = 1'b0;
        gap_en[3] = 1'b0;
        for (int s = 0; s < NS; s++) nb[s] = 0;
        checks++; if (n_obs !== 48) begin errors++; $display("FAIL bp_nbeats: got %0d want 48", n_obs); end
        for (int j = 0; j < n_obs; j++) begin
            int s;
            s = int'(obs_src[j]);
            snd = 4'(s + 2);
            checks++;
            if (obs_data[j] !== mk_data(s, nb[s] / 4, nb[s] % 4) || obs_dest[j] !== mk_dest(snd, nb[s] % 4) ||
                obs_last[j] !== (nb[s] % 4 == 3)) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h dest=%h want %h/%h", j, obs_data[j], obs_dest[j],
                         mk_data(s, nb[s] / 4, nb[s] % 4), mk_dest(snd, nb[s] % 4));
            end
            if (j > 0 && !obs_last[j - 1]) begin
                checks++;
                if (obs_src[j] !== obs_src[j - 1]) begin
                    errors++; $display("FAIL bp_interleave%0d: src=%0d want %0d", j, obs_src[j], obs_src[j - 1]);
                end
            end
            nb[s]++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_tready: violations=%0d want 0", viol); end
    endtask

    task automatic test_mid_packet();
        logic any_rdy;
        // route_ctrl change after the first beat must not alter the verdict.
        route_ctrl = 14'h040;
        clear_logs();
        add_pkt(0, 5, 4, 4'd1);
        run_until_obs(1, 50, "mid_rc");
        route_ctrl = 14'h080;
        wait_idle(50, "mid_rc");
        checks++; if (n_obs !== 4 || n_pulse !== 0 || obs_data[3] !== mk_data(0, 5, 3)) begin
            errors++; $display("FAIL mid_rc: beats=%0d pulses=%0d last=%h want 4/0/%h", n_obs, n_pulse, obs_data[3], mk_data(0, 5, 3));
        end
        // Asynchronous reset after beat 2 of a 5-beat packet.
        do_reset();
        route_ctrl = 14'h000;
        clear_logs();
        add_pkt(2, 0, 5, 4'd2);
        run_until_obs(2, 50, "mid_rst");
        checks++; if (cur_src !== 2'd2) begin errors++; $display("FAIL mid_rst_pre_src: got %0d want 2", cur_src); end
        aresetn = 1'b0;
        #1;
        any_rdy = src_tready[0] | src_tready[1] | src_tready[2] | src_tready[3];
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b want 0", m_tvalid); end
        checks++; if (any_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b want 0", any_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        checks++; if (cur_src !== 2'd0) begin errors++; $display("FAIL mid_rst_src: got %0d want 0", cur_src); end
        #1;
        aresetn = 1'b1;
        wait_idle(50, "mid_rst");
        checks++; if (n_obs !== 5 || obs_data[2] !== mk_data(2, 0, 2) || obs_last[4] !== 1'b1) begin
            errors++; $display("FAIL mid_rst_rest: beats=%0d data2=%h want 5/%h", n_obs, obs_data[2], mk_data(2, 0, 2));
        end
        checks++; if (n_pulse !== 0 || drop_cnt !== 2'd0) begin
            errors++; $display("FAIL mid_rst_drop: pulses=%0d cnt=%0d want 0/0", n_pulse, drop_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        route_ctrl = 14'h040;
        clear_logs();
        for (int p = 0; p < 5; p++) add_pkt(3, p, 2, 4'd0);
        wait_idle(100, "sat");
        checks++; if (n_pulse !== 5) begin errors++; $display("FAIL sat_pulses: got %0d want 5", n_pulse); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pulse_log[i] !== exp_cnt[i]) begin
                errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, pulse_log[i], exp_cnt[i]);
            end
        end
        checks++; if (n_obs !== 0) begin errors++; $display("FAIL sat_fwd: got %0d beats want 0", n_obs); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            wr[i] = 0; rd[i] = 0; gap[i] = 1'b0; gap_en[i] = 1'b0;
            src_tvalid[i] = 1'b0; src_tdata[i] = 32'h0; src_tkeep[i] = 4'h0;
            src_tlast[i] = 1'b0; src_tdest[i] = 14'h0;
        end
        clear_logs();
        test_reset();
        test_host_alone();
        test_p2p();
        test_round_robin();
        test_backpressure();
        test_mid_packet();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
